// File: rtl/medikit_pkg.sv
// Shared medicine-kit constants: scheduler FSM encodings and buzzer driver state codes.
// The buzzer driver decode uses REM_BASE/STATE_IDLE from here so both sides stay in step.
package medikit_pkg;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_RING_ON  = 2'd1;
  localparam logic [1:0] ST_RING_OFF = 2'd2;

  localparam logic [3:0] REM_BASE   = 4'b0110;
  localparam logic [3:0] STATE_IDLE = 4'b0000;

  function automatic logic [3:0] rem_code(input logic [1:0] idx);
    return REM_BASE + {2'b00, idx};
  endfunction

endpackage

// File: rtl/reminder_scheduler_snooze_timer.sv
// Per-slot snooze countdown, decremented on tick; load beats tick, clear beats both.
// Zero flag is combinational from the registered count; no backpressure.
module snooze_timer #(
  parameter int W = 8
) (
  input  logic         clk_base,
  input  logic         rst,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         tick,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk_base or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (tick && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/reminder_scheduler.sv
// Round-robin reminder arbiter driving the buzzer code with on/off beep cadence and auto-snooze.
// Grant one cycle after an eligible request in IDLE; exits (ack/drop/timeout) take effect next edge.
module reminder_scheduler
  import medikit_pkg::*;
#(
  parameter int N_SLOT       = 3,
  parameter int ON_TICKS     = 2,
  parameter int OFF_TICKS    = 2,
  parameter int RING_TICKS   = 30,
  parameter int SNOOZE_TICKS = 120,
  parameter int MAX_SNOOZE   = 2
) (
  input  logic              clk_base,
  input  logic              rst,
  input  logic              tick,
  input  logic [N_SLOT-1:0] req,
  input  logic              ack,
  output logic [N_SLOT-1:0] grant,
  output logic [N_SLOT-1:0] done,
  output logic [N_SLOT-1:0] missed,
  output logic [3:0]        state_out,
  output logic              buzz_en,
  output logic              tone_sel,
  output logic              busy
);

  localparam int IW     = 2;
  localparam int PH_MAX = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int RCW    = $clog2(RING_TICKS + 1);
  localparam int PCW    = (PH_MAX > 1) ? $clog2(PH_MAX + 1) : 1;
  localparam int SCW    = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;
  localparam int TW     = (SNOOZE_TICKS > 1) ? $clog2(SNOOZE_TICKS + 1) : 1;

  logic [1:0]        state;
  logic [IW-1:0]     gidx;
  logic [IW-1:0]     rr_ptr;
  logic [RCW-1:0]    ring_cnt;
  logic [PCW-1:0]    phase_cnt;
  logic [N_SLOT-1:0] served;
  logic [SCW-1:0]    snz_cnt [N_SLOT];
  logic [N_SLOT-1:0] snz_zero;
  logic [N_SLOT-1:0] snz_load;

  logic [N_SLOT-1:0] elig;
  logic [N_SLOT-1:0] pick_oh;
  logic [N_SLOT-1:0] done_nxt;
  logic [N_SLOT-1:0] missed_nxt;
  logic [IW-1:0]     pick;
  logic [IW-1:0]     next_ptr;
  logic              ringing;
  logic              do_ack;
  logic              do_drop;
  logic              do_tmo;
  logic              do_exit;
  logic              can_snooze;

  // First eligible slot at or after ptr, wrapping; only consulted when elig is nonzero.
  function automatic logic [IW-1:0] rr_pick(input logic [N_SLOT-1:0] el, input logic [IW-1:0] ptr);
    logic [IW-1:0] sel;
    logic          found;
    int            idx;
    sel   = ptr;
    found = 1'b0;
    for (int k = 0; k < N_SLOT; k++) begin
      idx = (int'(ptr) + k) % N_SLOT;
      if (!found && el[idx]) begin
        sel   = IW'(idx);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  always_comb begin
    elig       = req & ~served & snz_zero;
    pick       = rr_pick(elig, rr_ptr);
    ringing    = (state != ST_IDLE);
    can_snooze = (snz_cnt[gidx] < SCW'(MAX_SNOOZE));
    do_ack     = ringing & ack;
    do_drop    = ringing & ~ack & ~req[gidx];
    do_tmo     = ringing & ~ack & req[gidx] & tick & (ring_cnt == RCW'(RING_TICKS - 1));
    do_exit    = do_ack | do_drop | do_tmo;
    next_ptr   = (gidx == IW'(N_SLOT - 1)) ? '0 : gidx + IW'(1);
    pick_oh    = '0;
    done_nxt   = '0;
    missed_nxt = '0;
    snz_load   = '0;
    for (int i = 0; i < N_SLOT; i++) begin
      pick_oh[i]    = (pick == IW'(i));
      done_nxt[i]   = do_ack & (gidx == IW'(i));
      missed_nxt[i] = do_tmo & ~can_snooze & (gidx == IW'(i));
      snz_load[i]   = do_tmo & can_snooze & (gidx == IW'(i));
    end
  end

  for (genvar i = 0; i < N_SLOT; i++) begin : g_snz
    snooze_timer #(.W(TW)) u_snooze_timer (
      .clk_base (clk_base),
      .rst      (rst),
      .clear    (~req[i]),
      .load     (snz_load[i]),
      .load_val (TW'(SNOOZE_TICKS)),
      .tick     (tick),
      .zero     (snz_zero[i])
    );
  end

  always_ff @(posedge clk_base or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      gidx      <= '0;
      rr_ptr    <= '0;
      ring_cnt  <= '0;
      phase_cnt <= '0;
      served    <= '0;
      grant     <= '0;
      done      <= '0;
      missed    <= '0;
      state_out <= STATE_IDLE;
      buzz_en   <= 1'b0;
      tone_sel  <= 1'b0;
      busy      <= 1'b0;
      for (int i = 0; i < N_SLOT; i++) snz_cnt[i] <= '0;
    end else begin
      done   <= done_nxt;
      missed <= missed_nxt;
      // A served slot stays ineligible until upstream withdraws its request.
      served <= req & (served | done_nxt | missed_nxt);
      if (do_exit) begin
        state         <= ST_IDLE;
        grant         <= '0;
        buzz_en       <= 1'b0;
        state_out     <= STATE_IDLE;
        busy          <= 1'b0;
        phase_cnt     <= '0;
        rr_ptr        <= next_ptr;
        snz_cnt[gidx] <= (do_tmo && can_snooze) ? snz_cnt[gidx] + SCW'(1) : '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (|elig) begin
              state     <= ST_RING_ON;
              gidx      <= pick;
              grant     <= pick_oh;
              ring_cnt  <= '0;
              phase_cnt <= '0;
              tone_sel  <= ~tone_sel;
              buzz_en   <= 1'b1;
              state_out <= rem_code(pick);
              busy      <= 1'b1;
            end
          end
          ST_RING_ON: begin
            if (tick) begin
              ring_cnt <= ring_cnt + RCW'(1);
              if (phase_cnt == PCW'(ON_TICKS - 1)) begin
                phase_cnt <= '0;
                state     <= ST_RING_OFF;
                buzz_en   <= 1'b0;
              end else begin
                phase_cnt <= phase_cnt + PCW'(1);
              end
            end
          end
          ST_RING_OFF: begin
            if (tick) begin
              ring_cnt <= ring_cnt + RCW'(1);
              if (phase_cnt == PCW'(OFF_TICKS - 1)) begin
                phase_cnt <= '0;
                state     <= ST_RING_ON;
                buzz_en   <= 1'b1;
                tone_sel  <= ~tone_sel;
              end else begin
                phase_cnt <= phase_cnt + PCW'(1);
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_reminder_scheduler.sv
// Directed bench for reminder_scheduler with default parameters; ticks are pulsed by the bench.
module tb_reminder_scheduler;

  logic       clk_base = 1'b0;
  logic       rst;
  logic       tick;
  logic [2:0] req;
  logic       ack;
  logic [2:0] grant;
  logic [2:0] done;
  logic [2:0] missed;
  logic [3:0] state_out;
  logic       buzz_en;
  logic       tone_sel;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  reminder_scheduler dut (
    .clk_base  (clk_base),
    .rst       (rst),
    .tick      (tick),
    .req       (req),
    .ack       (ack),
    .grant     (grant),
    .done      (done),
    .missed    (missed),
    .state_out (state_out),
    .buzz_en   (buzz_en),
    .tone_sel  (tone_sel),
    .busy      (busy)
  );

  always #5 clk_base = ~clk_base;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk_base);
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
    step();
  endtask

  task automatic reset_dut();
    req = 3'b000;
    ack = 1'b0;
    tick = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst  = 1'b1;
    tick = 1'b0;
    req  = 3'b000;
    ack  = 1'b0;
    step();
    step();
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_missed", 32'(missed), 32'h0);
    check("rst_state", 32'(state_out), 32'h0);
    check("rst_buzz", 32'(buzz_en), 32'h0);
    check("rst_tone", 32'(tone_sel), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;

    // single request, ack on the 5th tick
    req = 3'b001;
    step();
    check("t1_grant", 32'(grant), 32'h1);
    check("t1_state", 32'(state_out), 32'h6);
    check("t1_buzz0", 32'(buzz_en), 32'h1);
    check("t1_busy", 32'(busy), 32'h1);
    check("t1_tone0", 32'(tone_sel), 32'h1);
    pulse_tick();
    check("t1_buzz1", 32'(buzz_en), 32'h1);
    pulse_tick();
    check("t1_buzz2", 32'(buzz_en), 32'h0);
    check("t1_state_off", 32'(state_out), 32'h6);
    pulse_tick();
    check("t1_buzz3", 32'(buzz_en), 32'h0);
    pulse_tick();
    check("t1_buzz4", 32'(buzz_en), 32'h1);
    check("t1_tone4", 32'(tone_sel), 32'h0);
    tick = 1'b1;
    ack  = 1'b1;
    step();
    tick = 1'b0;
    ack  = 1'b0;
    check("t1_done", 32'(done), 32'h1);
    check("t1_grant_off", 32'(grant), 32'h0);
    check("t1_state_off2", 32'(state_out), 32'h0);
    check("t1_buzz_off", 32'(buzz_en), 32'h0);
    step();
    check("t1_done_clr", 32'(done), 32'h0);
    req = 3'b000;
    step();

    // fairness with all requests held
    reset_dut();
    req = 3'b111;
    step();
    check("t2_g0", 32'(grant), 32'h1);
    check("t2_s0", 32'(state_out), 32'h6);
    ack = 1'b1; step(); ack = 1'b0;
    check("t2_d0", 32'(done), 32'h1);
    req = 3'b110;
    step();
    check("t2_g1", 32'(grant), 32'h2);
    check("t2_s1", 32'(state_out), 32'h7);
    req = 3'b111;
    ack = 1'b1; step(); ack = 1'b0;
    check("t2_d1", 32'(done), 32'h2);
    req = 3'b101;
    step();
    check("t2_g2", 32'(grant), 32'h4);
    check("t2_s2", 32'(state_out), 32'h8);
    req = 3'b111;
    ack = 1'b1; step(); ack = 1'b0;
    check("t2_d2", 32'(done), 32'h4);
    req = 3'b011;
    step();
    check("t2_g3", 32'(grant), 32'h1);
    ack = 1'b1; step(); ack = 1'b0;
    req = 3'b000;
    step();

    // slot1 unanswered: two snoozes then missed
    reset_dut();
    req = 3'b010;
    step();
    check("t3_grant", 32'(grant), 32'h2);
    for (int r = 0; r < 2; r++) begin
      repeat (29) pulse_tick();
      check("t3_ringing", 32'(grant), 32'h2);
      pulse_tick();
      check("t3_tmo_grant", 32'(grant), 32'h0);
      check("t3_tmo_missed", 32'(missed), 32'h0);
      repeat (119) pulse_tick();
      check("t3_snoozing", 32'(grant), 32'h0);
      pulse_tick();
      check("t3_regrant", 32'(grant), 32'h2);
    end
    repeat (29) pulse_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
    check("t3_missed", 32'(missed), 32'h2);
    check("t3_miss_grant", 32'(grant), 32'h0);
    step();
    check("t3_missed_clr", 32'(missed), 32'h0);
    repeat (130) pulse_tick();
    check("t3_no_regrant", 32'(grant), 32'h0);
    check("t3_idle", 32'(busy), 32'h0);
    req = 3'b000;
    step();

    // slot2 served while slot0 snoozes
    reset_dut();
    req = 3'b001;
    step();
    check("t4_g0", 32'(grant), 32'h1);
    repeat (30) pulse_tick();
    check("t4_snz", 32'(grant), 32'h0);
    req = 3'b101;
    step();
    check("t4_g2", 32'(grant), 32'h4);
    check("t4_s2", 32'(state_out), 32'h8);
    ack = 1'b1; step(); ack = 1'b0;
    check("t4_d2", 32'(done), 32'h4);
    req = 3'b001;
    repeat (119) pulse_tick();
    check("t4_still_snz", 32'(grant), 32'h0);
    pulse_tick();
    check("t4_regrant0", 32'(grant), 32'h1);
    check("t4_snzcnt", 32'(dut.snz_cnt[0]), 32'h1);

    // ack coinciding with timeout tick
    repeat (29) pulse_tick();
    tick = 1'b1;
    ack  = 1'b1;
    step();
    tick = 1'b0;
    ack  = 1'b0;
    check("t5_done", 32'(done), 32'h1);
    check("t5_missed", 32'(missed), 32'h0);
    step();
    check("t5_missed2", 32'(missed), 32'h0);
    check("t5_snzcnt", 32'(dut.snz_cnt[0]), 32'h0);

    // async reset mid ring
    req = 3'b000;
    step();
    req = 3'b010;
    step();
    check("t6_grant", 32'(grant), 32'h2);
    repeat (150) pulse_tick();
    check("t6_regrant", 32'(grant), 32'h2);
    check("t6_snzcnt", 32'(dut.snz_cnt[1]), 32'h1);
    pulse_tick();
    check("t6_buzz_on", 32'(buzz_en), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("t6_async_buzz", 32'(buzz_en), 32'h0);
    check("t6_async_state", 32'(state_out), 32'h0);
    check("t6_async_grant", 32'(grant), 32'h0);
    check("t6_async_busy", 32'(busy), 32'h0);
    step();
    check("t6_rst_done", 32'(done), 32'h0);
    rst = 1'b0;
    step();
    check("t6_post_grant", 32'(grant), 32'h2);
    check("t6_post_state", 32'(state_out), 32'h7);
    check("t6_post_buzz", 32'(buzz_en), 32'h1);
    check("t6_post_snzcnt", 32'(dut.snz_cnt[1]), 32'h0);
    req = 3'b000;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reminder_scheduler.md
# reminder_scheduler

Sequences the medicine-kit buzzer: arbitrates up to three compartment reminder requests round-robin, then drives the buzzer driver's `state_in` code and enable with an on/off beep cadence. The user acknowledges with a button pulse. Unanswered reminders auto-snooze a bounded number of times before being reported missed. Sits between the compartment schedule logic (upstream `req`) and `buzzerDriver` (downstream `state_in`).

## Interface
- `N_SLOT`, 3: number of compartments; legal range 1..3, because only three driver reminder codes exist.
- `ON_TICKS`, 2: ticks the buzzer sounds per beep.
- `OFF_TICKS`, 2: ticks of silence between beeps.
- `RING_TICKS`, 30: ticks a reminder rings before timeout.
- `SNOOZE_TICKS`, 120: ticks a snoozed slot stays ineligible.
- `MAX_SNOOZE`, 2: snoozes allowed before a reminder is declared missed.

Ports:
- `clk_base` in 1: sole clock.
- `rst` in 1: asynchronous, active-high reset.
- `tick` in 1: one-cycle timebase strobe, synchronous to `clk_base`.
- `req` in N_SLOT: level request per slot; upstream holds it until `done` or `missed` for that slot.
- `ack` in 1: one-cycle user acknowledge pulse.
- `grant` out N_SLOT: one-hot slot currently ringing; zero otherwise.
- `done` out N_SLOT: one-cycle pulse, slot acknowledged.
- `missed` out N_SLOT: one-cycle pulse, slot exhausted its snoozes.
- `state_out` out 4: 4'b0000 when not ringing; 4'b0110 + slot index while ringing (slot0=0110, slot1=0111, slot2=1000).
- `buzz_en` out 1: high during the beep-on phase.
- `tone_sel` out 1: toggles at the start of each beep-on phase.
- `busy` out 1: FSM not in IDLE.

## Operation
- Slot eligibility: `req[i] & ~served[i] & (snz_timer[i]==0)`.
  - `served[i]` sets on `done[i]` or `missed[i]`.
  - `served[i]` clears in any cycle with `req[i]`=0.
- FSM states: IDLE, RING_ON, RING_OFF.
- IDLE:
  - If any slot is eligible, pick the first eligible slot at or after `rr_ptr` (wrapping modulo N_SLOT).
  - Register `grant`, clear `ring_cnt` and `phase_cnt`, toggle `tone_sel`, go to RING_ON.
- RING_ON:
  - On each `tick`, increment `ring_cnt` and `phase_cnt`.
  - When `phase_cnt` reaches ON_TICKS, clear it and go to RING_OFF.
- RING_OFF:
  - Same counting as RING_ON.
  - When `phase_cnt` reaches OFF_TICKS, clear it, toggle `tone_sel`, and go to RING_ON.
- Exits from RING_ON or RING_OFF, in priority order:
  1. `ack`: pulse `done[g]`, clear `snz_cnt[g]`, set `rr_ptr` to g+1, go to IDLE.
  2. `req[g]` dropped: abort silently (no `done`/`missed`), clear `snz_cnt[g]`, set `rr_ptr` to g+1, go to IDLE.
  3. Timeout (`tick` with `ring_cnt`==RING_TICKS-1):
     - If `snz_cnt[g]` < MAX_SNOOZE: increment it, load `snz_timer[g]` with SNOOZE_TICKS, go to IDLE.
     - Otherwise: pulse `missed[g]`, clear `snz_cnt[g]`, go to IDLE.
     - In both cases `rr_ptr` becomes g+1.
- `ack` in IDLE is ignored.
- Snooze timers: per slot, independent of the FSM. Each decrements on `tick` while nonzero.
  - A load and a tick in the same cycle: the load wins.
  - A timer is cleared when its `req` is 0.
- Arithmetic:
  - `ring_cnt` width: $clog2(RING_TICKS+1).
  - `phase_cnt` width: sized to max(ON_TICKS, OFF_TICKS).
  - `snz_cnt` width: $clog2(MAX_SNOOZE+1).
  - No counter may wrap.

## Timing
- Reset values:
  - Outputs: `grant`, `done`, `missed`, `buzz_en`, `tone_sel`, `busy` all 0; `state_out` = 0000.
  - Internal: FSM = IDLE, `rr_ptr` = 0, all counters, timers and `served` bits = 0.
- Reset asserted mid-ring silences the buzzer asynchronously. No `done`/`missed` pulse is emitted.
- All outputs are registered.
- `req` rising in cycle n (slot eligible, FSM in IDLE): `grant`, `state_out` and `buzz_en` become valid at edge n+1.
- `ack` sampled in cycle n: `done` is high for cycle n+1 only; `grant`, `state_out` and `buzz_en` are 0 from n+1.
- Earliest re-grant after any exit is the following cycle (IDLE spends one cycle).
- `ack` and timeout in the same cycle: `ack` wins.
- `req` drop and `ack` in the same cycle: `done` is still pulsed.

## Structure
- Shared package `medikit_pkg`:
  - FSM state localparams.
  - Driver reminder codes REM_BASE=4'b0110 and STATE_IDLE=4'b0000. `buzzerDriver` decode must use the same constants.
- Sub-module `snooze_timer`, instantiated per slot via generate.
  - Inputs: load, load value, tick, clear.
  - Outputs: zero flag.
- The round-robin pick stays in the top module as a small function.

## Test plan
- Single request, then `ack` on the 5th tick:
  - Response: `req`=001 → `state_out`=0110, `buzz_en` high 2 ticks / low 2 ticks; `done`=001 for one cycle; `state_out`=0000 next cycle.
- Fairness: `req`=111 held, `ack` after each grant:
  - Response: `grant` order 001, 010, 100, 001; `state_out` 0110, 0111, 1000.
- No `ack`, MAX_SNOOZE=2, slot1 only:
  - Response: times out after 30 ticks, silent 120 ticks; repeats twice; on the third timeout `missed`=010 and no regrant while `req` is held.
- Slot0 snoozing while slot2 requests:
  - Response: slot2 granted during slot0's snooze; slot0 regranted after its timer expires.
- `ack` and timeout on the same tick:
  - Response: `done` pulses, `missed` does not, `snz_cnt` clears.
- `rst` pulsed mid RING_ON:
  - Response: `buzz_en`=0 and `state_out`=0000 immediately; after release, a held `req` is regranted with `snz_cnt`=0.
